// File: rtl/csr_trap_pkg.sv
// Shared constants for the trap/return sequencer: CSR addresses, cause codes,
// status/enable bit positions and the sequencer state encoding.
package csr_trap_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;

    // Exception codes; interrupt codes are paired with the cause MSB set.
    localparam logic [5:0] CAUSE_ILLEGAL = 6'd2;
    localparam logic [5:0] CAUSE_BREAK   = 6'd3;
    localparam logic [5:0] CAUSE_ECALL   = 6'd11;
    localparam logic [5:0] CAUSE_IRQ_EXT = 6'd11;
    localparam logic [5:0] CAUSE_IRQ_SFT = 6'd3;
    localparam logic [5:0] CAUSE_IRQ_TMR = 6'd7;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MSIE     = 3;
    localparam int MIE_MTIE     = 7;
    localparam int MIE_MEIE     = 11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_W_MEPC    = 3'd1,
        S_W_MCAUSE  = 3'd2,
        S_W_MSTATUS = 3'd3,
        S_W_MRET    = 3'd4,
        S_JUMP      = 3'd5
    } state_t;

endpackage

// File: rtl/csr_trap_ctrl_cause_enc.sv
// Priority encoder for execute-stage exceptions and pending machine interrupts.
module trap_cause_enc
    import csr_trap_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  instr_vld_i,
    input  logic                  illegal_i,
    input  logic                  ebreak_i,
    input  logic                  ecall_i,
    input  logic                  ext_irq_i,
    input  logic                  sft_irq_i,
    input  logic                  tmr_irq_i,
    input  logic                  mstatus_mie_i,
    input  logic [DATA_WIDTH-1:0] mie_i,
    output logic                  trap_vld_o,
    output logic                  is_irq_o,
    output logic [DATA_WIDTH-1:0] cause_o
);

    logic [5:0] w_code;
    logic       w_unused_mie;

    assign w_unused_mie = ^mie_i;

    always_comb begin
        trap_vld_o = 1'b1;
        is_irq_o   = 1'b0;
        w_code     = '0;
        if (instr_vld_i && illegal_i) begin
            w_code = CAUSE_ILLEGAL;
        end else if (instr_vld_i && ebreak_i) begin
            w_code = CAUSE_BREAK;
        end else if (instr_vld_i && ecall_i) begin
            w_code = CAUSE_ECALL;
        end else if (mstatus_mie_i && ext_irq_i && mie_i[MIE_MEIE]) begin
            is_irq_o = 1'b1;
            w_code   = CAUSE_IRQ_EXT;
        end else if (mstatus_mie_i && sft_irq_i && mie_i[MIE_MSIE]) begin
            is_irq_o = 1'b1;
            w_code   = CAUSE_IRQ_SFT;
        end else if (mstatus_mie_i && tmr_irq_i && mie_i[MIE_MTIE]) begin
            is_irq_o = 1'b1;
            w_code   = CAUSE_IRQ_TMR;
        end else begin
            trap_vld_o = 1'b0;
        end
    end

    assign cause_o = {is_irq_o, (DATA_WIDTH-1)'(w_code)};

endmodule

// File: rtl/csr_trap_ctrl.sv
// Trap/return sequencer: writes mepc, mcause, mstatus over the control CSR
// port one per cycle, then redirects the PC to mtvec (trap) or mepc (mret).
//
// state       | meaning
// S_IDLE      | waiting for an event; acceptance evaluated every cycle
// S_W_MEPC    | writing mepc <- faulting/interrupted PC
// S_W_MCAUSE  | writing mcause <- latched cause
// S_W_MSTATUS | writing mstatus with MPIE<-MIE, MIE<-0
// S_W_MRET    | writing mstatus with MIE<-MPIE, MPIE<-1
// S_JUMP      | one-cycle redirect strobe
module csr_trap_ctrl
    import csr_trap_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CSR_AW     = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic                  instr_vld_i,
    input  logic                  ecall_i,
    input  logic                  ebreak_i,
    input  logic                  illegal_i,
    input  logic                  mret_i,
    input  logic                  ext_irq_i,
    input  logic                  sft_irq_i,
    input  logic                  tmr_irq_i,
    input  logic                  ex_csr_we_i,
    input  logic [DATA_WIDTH-1:0] csr_mstatus_i,
    input  logic [DATA_WIDTH-1:0] csr_mie_i,
    input  logic [DATA_WIDTH-1:0] csr_mtvec_i,
    input  logic [DATA_WIDTH-1:0] csr_mepc_i,
    output logic                  clt_we_o,
    output logic [CSR_AW-1:0]     clt_addr_o,
    output logic [DATA_WIDTH-1:0] clt_data_o,
    output logic                  hold_o,
    output logic                  jump_o,
    output logic [DATA_WIDTH-1:0] jump_addr_o
);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_cause;
    logic                  r_is_irq;
    logic                  r_clt_we;
    logic [CSR_AW-1:0]     r_clt_addr;
    logic [DATA_WIDTH-1:0] r_clt_data;
    logic                  r_jump;
    logic [DATA_WIDTH-1:0] r_jump_addr;

    logic                  w_trap_vld;
    logic                  w_is_irq;
    logic [DATA_WIDTH-1:0] w_cause;
    logic                  w_accept_ok;
    logic                  w_trap_go;
    logic                  w_mret_go;
    logic [DATA_WIDTH-1:0] w_mstatus_trap;
    logic [DATA_WIDTH-1:0] w_mstatus_ret;
    logic [DATA_WIDTH-1:0] w_trap_base;
    logic [DATA_WIDTH-1:0] w_trap_target;

    trap_cause_enc #(.DATA_WIDTH(DATA_WIDTH)) u_cause_enc (
        .instr_vld_i   (instr_vld_i),
        .illegal_i     (illegal_i),
        .ebreak_i      (ebreak_i),
        .ecall_i       (ecall_i),
        .ext_irq_i     (ext_irq_i),
        .sft_irq_i     (sft_irq_i),
        .tmr_irq_i     (tmr_irq_i),
        .mstatus_mie_i (csr_mstatus_i[MSTATUS_MIE]),
        .mie_i         (csr_mie_i),
        .trap_vld_o    (w_trap_vld),
        .is_irq_o      (w_is_irq),
        .cause_o       (w_cause)
    );

    // A concurrent execute-stage CSR write defers acceptance by a cycle.
    assign w_accept_ok = (r_state == S_IDLE) & instr_vld_i & ~ex_csr_we_i;
    assign w_trap_go   = w_accept_ok & w_trap_vld;
    assign w_mret_go   = w_accept_ok & ~w_trap_vld & mret_i;

    assign hold_o = ~rst & ((r_state == S_IDLE) ? (w_trap_go | w_mret_go)
                                                : (r_state != S_JUMP));

    always_comb begin
        w_mstatus_trap               = csr_mstatus_i;
        w_mstatus_trap[MSTATUS_MPIE] = csr_mstatus_i[MSTATUS_MIE];
        w_mstatus_trap[MSTATUS_MIE]  = 1'b0;
        w_mstatus_ret                = csr_mstatus_i;
        w_mstatus_ret[MSTATUS_MIE]   = csr_mstatus_i[MSTATUS_MPIE];
        w_mstatus_ret[MSTATUS_MPIE]  = 1'b1;
    end

    assign w_trap_base   = {csr_mtvec_i[DATA_WIDTH-1:2], 2'b00};
    assign w_trap_target = (csr_mtvec_i[1:0] == 2'b01 && r_is_irq)
                         ? w_trap_base + {r_cause[DATA_WIDTH-3:0], 2'b00}
                         : w_trap_base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cause     <= '0;
            r_is_irq    <= 1'b0;
            r_clt_we    <= 1'b0;
            r_clt_addr  <= '0;
            r_clt_data  <= '0;
            r_jump      <= 1'b0;
            r_jump_addr <= '0;
        end else begin
            r_clt_we    <= 1'b0;
            r_clt_addr  <= '0;
            r_clt_data  <= '0;
            r_jump      <= 1'b0;
            r_jump_addr <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_trap_go) begin
                        r_cause    <= w_cause;
                        r_is_irq   <= w_is_irq;
                        r_state    <= S_W_MEPC;
                        r_clt_we   <= 1'b1;
                        r_clt_addr <= CSR_AW'(CSR_MEPC);
                        r_clt_data <= pc_i;
                    end else if (w_mret_go) begin
                        r_state    <= S_W_MRET;
                        r_clt_we   <= 1'b1;
                        r_clt_addr <= CSR_AW'(CSR_MSTATUS);
                        r_clt_data <= w_mstatus_ret;
                    end
                end
                S_W_MEPC: begin
                    r_state    <= S_W_MCAUSE;
                    r_clt_we   <= 1'b1;
                    r_clt_addr <= CSR_AW'(CSR_MCAUSE);
                    r_clt_data <= r_cause;
                end
                S_W_MCAUSE: begin
                    r_state    <= S_W_MSTATUS;
                    r_clt_we   <= 1'b1;
                    r_clt_addr <= CSR_AW'(CSR_MSTATUS);
                    r_clt_data <= w_mstatus_trap;
                end
                S_W_MSTATUS: begin
                    r_state     <= S_JUMP;
                    r_jump      <= 1'b1;
                    r_jump_addr <= w_trap_target;
                end
                S_W_MRET: begin
                    r_state     <= S_JUMP;
                    r_jump      <= 1'b1;
                    r_jump_addr <= csr_mepc_i;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign clt_we_o    = r_clt_we;
    assign clt_addr_o  = r_clt_addr;
    assign clt_data_o  = r_clt_data;
    assign jump_o      = r_jump;
    assign jump_addr_o = r_jump_addr;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Scoreboard bench for csr_trap_ctrl: a reference model predicts each control
// port write and redirect with its cycle; a monitor compares as outputs appear.
module tb_csr_trap_ctrl;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] pc_i;
    logic          instr_vld_i, ecall_i, ebreak_i, illegal_i, mret_i;
    logic          ext_irq_i, sft_irq_i, tmr_irq_i, ex_csr_we_i;
    logic [DW-1:0] csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i;
    logic          clt_we_o;
    logic [11:0]   clt_addr_o;
    logic [DW-1:0] clt_data_o;
    logic          hold_o, jump_o;
    logic [DW-1:0] jump_addr_o;

    csr_trap_ctrl #(.DATA_WIDTH(DW), .CSR_AW(12)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .instr_vld_i(instr_vld_i),
        .ecall_i(ecall_i), .ebreak_i(ebreak_i), .illegal_i(illegal_i), .mret_i(mret_i),
        .ext_irq_i(ext_irq_i), .sft_irq_i(sft_irq_i), .tmr_irq_i(tmr_irq_i),
        .ex_csr_we_i(ex_csr_we_i), .csr_mstatus_i(csr_mstatus_i), .csr_mie_i(csr_mie_i),
        .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
        .clt_we_o(clt_we_o), .clt_addr_o(clt_addr_o), .clt_data_o(clt_data_o),
        .hold_o(hold_o), .jump_o(jump_o), .jump_addr_o(jump_addr_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_jump;
        int          cyc;
        logic [11:0] addr;
        logic [63:0] data;
    } exp_t;

    typedef struct {
        logic [63:0] pc, mstatus, mie, mtvec, mepc;
        bit          ill, brk, ecall, mret, ext, sft, tmr, defer;
    } txn_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every control-port write or redirect must match the queue head.
    exp_t e;
    bit   ok;
    always @(negedge clk) begin
        if (!rst) begin
            if (clt_we_o || jump_o) begin
                n_total++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_out: cycle %0d we=%b addr=%h data=%h jump=%b jaddr=%h",
                             cyc, clt_we_o, clt_addr_o, clt_data_o, jump_o, jump_addr_o);
                end else begin
                    e = q.pop_front();
                    if (e.is_jump)
                        ok = jump_o && !clt_we_o && jump_addr_o == e.data && !hold_o && cyc == e.cyc;
                    else
                        ok = clt_we_o && !jump_o && clt_addr_o == e.addr && clt_data_o == e.data
                             && hold_o && cyc == e.cyc;
                    if (ok) n_pass++;
                    else $display("FAIL %s: got cyc=%0d we=%b addr=%h data=%h jump=%b jaddr=%h hold=%b want cyc=%0d addr=%h data=%h",
                                  e.is_jump ? "jump" : "csr_write", cyc, clt_we_o, clt_addr_o,
                                  clt_data_o, jump_o, jump_addr_o, hold_o, e.cyc, e.addr, e.data);
                end
            end
            if (!clt_we_o) chk("idle_port_zero", 64'(clt_addr_o == 0 && clt_data_o == 0), 64'd1);
        end
    end

    // Reference model: decide what the instruction/interrupt mix should do and
    // enqueue the resulting port activity relative to acceptance cycle T.
    task automatic model_push(input txn_t t, input int T, output bit evt);
        logic [63:0] cause, ms, target;
        bit trap, irq, ie;
        trap = 1; irq = 0; cause = 0;
        ie = t.mstatus[3];
        if (t.ill)                          cause = 2;
        else if (t.brk)                     cause = 3;
        else if (t.ecall)                   cause = 11;
        else if (ie && t.ext && t.mie[11])  begin irq = 1; cause = 11; end
        else if (ie && t.sft && t.mie[3])   begin irq = 1; cause = 3;  end
        else if (ie && t.tmr && t.mie[7])   begin irq = 1; cause = 7;  end
        else trap = 0;
        evt = trap || t.mret;
        if (trap) begin
            ms = (t.mstatus & ~64'h88) | (t.mstatus[3] ? 64'h80 : 64'h0);
            target = t.mtvec & ~64'h3;
            if (irq && t.mtvec[1:0] == 2'd1) target = target + 4 * cause;
            if (irq) cause = cause + 64'h8000_0000_0000_0000;
            q.push_back('{0, T + 1, 12'h341, t.pc});
            q.push_back('{0, T + 2, 12'h342, cause});
            q.push_back('{0, T + 3, 12'h300, ms});
            q.push_back('{1, T + 4, 12'h000, target});
        end else if (t.mret) begin
            ms = (t.mstatus & ~64'h08) | 64'h80 | (t.mstatus[7] ? 64'h08 : 64'h0);
            q.push_back('{0, T + 1, 12'h300, ms});
            q.push_back('{1, T + 2, 12'h000, t.mepc});
        end
    endtask

    task automatic apply(input txn_t t);
        pc_i = t.pc; csr_mstatus_i = t.mstatus; csr_mie_i = t.mie;
        csr_mtvec_i = t.mtvec; csr_mepc_i = t.mepc;
        illegal_i = t.ill; ebreak_i = t.brk; ecall_i = t.ecall; mret_i = t.mret;
        ext_irq_i = t.ext; sft_irq_i = t.sft; tmr_irq_i = t.tmr;
        instr_vld_i = 1'b1;
        ex_csr_we_i = t.defer;
    endtask

    task automatic clear_events();
        instr_vld_i = 0; illegal_i = 0; ebreak_i = 0; ecall_i = 0; mret_i = 0;
        ext_irq_i = 0; sft_irq_i = 0; tmr_irq_i = 0; ex_csr_we_i = 0;
    endtask

    task automatic drain(input string name);
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL %s_missing: %0d expected outputs never appeared (cycle %0d)", name, q.size(), cyc);
            q.delete();
        end
    endtask

    task automatic run_txn(input txn_t t, input string name);
        int T;
        bit evt;
        @(posedge clk); #1;
        apply(t);
        if (t.defer) begin
            #1 chk({name, "_defer_hold"}, 64'(hold_o), 64'd0);
            @(posedge clk); #1;
            ex_csr_we_i = 1'b0;
        end
        T = cyc;
        model_push(t, T, evt);
        #1 chk({name, "_accept_hold"}, 64'(hold_o), 64'(evt));
        @(posedge clk); #1;
        clear_events();
        repeat (6) @(posedge clk);
        #1 drain(name);
    endtask

    function automatic txn_t blank();
        txn_t t;
        t.pc = 0; t.mstatus = 0; t.mie = 0; t.mtvec = 0; t.mepc = 0;
        t.ill = 0; t.brk = 0; t.ecall = 0; t.mret = 0;
        t.ext = 0; t.sft = 0; t.tmr = 0; t.defer = 0;
        return t;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        txn_t t;
        int   T;
        rst = 1'b1;
        pc_i = 0; csr_mstatus_i = 0; csr_mie_i = 0; csr_mtvec_i = 0; csr_mepc_i = 0;
        clear_events();
        #2;
        chk("rst_we", 64'(clt_we_o), 0);
        chk("rst_addr", 64'(clt_addr_o), 0);
        chk("rst_data", clt_data_o, 0);
        chk("rst_hold", 64'(hold_o), 0);
        chk("rst_jump", 64'(jump_o), 0);
        chk("rst_jaddr", jump_addr_o, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        t = blank(); t.ecall = 1; t.pc = 64'h8000_0010; t.mtvec = 64'h8000_0100; t.mstatus = 64'h8;
        run_txn(t, "ecall");

        t = blank(); t.tmr = 1; t.mie = 64'h888; t.mstatus = 64'h8; t.mtvec = 64'h8000_0101;
        t.pc = 64'h8000_0200;
        run_txn(t, "vec_timer");

        // Masked external interrupt: nothing may happen for 20 cycles.
        t = blank(); t.ext = 1; t.mie = 64'h888; t.mstatus = 64'h0; t.pc = 64'h8000_0300;
        @(posedge clk); #1;
        apply(t);
        for (int i = 0; i < 20; i++) begin
            #1 chk("masked_hold", 64'(hold_o), 0);
            @(posedge clk); #1;
        end
        clear_events();
        drain("masked");

        t = blank(); t.mret = 1; t.mstatus = 64'h80; t.mepc = 64'h8000_0010; t.pc = 64'h8000_0400;
        run_txn(t, "mret");

        t = blank(); t.ill = 1; t.ext = 1; t.mie = 64'h888; t.mstatus = 64'h8; t.pc = 64'h8000_0500;
        t.mtvec = 64'h8000_0101;
        run_txn(t, "ill_vs_ext");

        t = blank(); t.ecall = 1; t.defer = 1; t.pc = 64'h8000_0600; t.mtvec = 64'h8000_0100;
        t.mstatus = 64'h8;
        run_txn(t, "deferred");

        t = blank(); t.mret = 1; t.sft = 1; t.mie = 64'h8; t.mstatus = 64'h88; t.pc = 64'h8000_0700;
        t.mtvec = 64'h8000_0001; t.mepc = 64'h1234;
        run_txn(t, "irq_vs_mret");

        // Reset pulsed while the mcause write is on the port.
        t = blank(); t.ecall = 1; t.pc = 64'h8000_0800; t.mtvec = 64'h8000_0100; t.mstatus = 64'h8;
        @(posedge clk); #1;
        apply(t);
        T = cyc;
        q.push_back('{0, T + 1, 12'h341, t.pc});
        @(posedge clk); #1;
        clear_events();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_we", 64'(clt_we_o), 0);
        chk("midrst_addr", 64'(clt_addr_o), 0);
        chk("midrst_data", clt_data_o, 0);
        chk("midrst_hold", 64'(hold_o), 0);
        chk("midrst_jump", 64'(jump_o), 0);
        chk("midrst_jaddr", jump_addr_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drain("midrst");
        run_txn(t, "after_rst");

        for (int i = 0; i < 60; i++) begin
            t = blank();
            t.pc      = {$urandom, $urandom} & ~64'h3;
            t.mstatus = {$urandom, $urandom};
            t.mie     = {32'h0, $urandom};
            t.mtvec   = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) t.mtvec[1:0] = 2'b01;
            t.mepc    = {$urandom, $urandom};
            t.ill     = ($urandom_range(0, 7) == 0);
            t.brk     = ($urandom_range(0, 7) == 0);
            t.ecall   = ($urandom_range(0, 7) == 0);
            t.mret    = ($urandom_range(0, 3) == 0);
            t.ext     = ($urandom_range(0, 2) == 0);
            t.sft     = ($urandom_range(0, 2) == 0);
            t.tmr     = ($urandom_range(0, 2) == 0);
            t.defer   = ($urandom_range(0, 3) == 0);
            run_txn(t, "random");
        end

        repeat (2) @(posedge clk);
        #1 drain("final");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
